// File: rtl/scu_isa_pkg.sv
// ISA constants, field positions and decode helpers for the SCU issue stage.
// Shared by the issue stage, its scoreboard and the bus interface.
package scu_isa_pkg;

    localparam int unsigned NREG = 64;
    localparam int unsigned AW   = 6;
    localparam int unsigned DW   = 32;

    localparam int unsigned OPC_LSB = 28;
    localparam int unsigned RD_LSB  = 22;
    localparam int unsigned RS_LSB  = 16;
    localparam int unsigned RT_LSB  = 10;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_NEG  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_BRZ  = 4'b1001;
    localparam logic [3:0] OP_JM   = 4'b1010;
    localparam logic [3:0] OP_BRN  = 4'b1011;
    localparam logic [3:0] OP_LD   = 4'b1110;
    localparam logic [3:0] OP_SVPC = 4'b1111;

    typedef enum logic {
        ST_EMPTY,
        ST_HELD
    } hold_state_e;

    typedef struct packed {
        logic [3:0]    opcode;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic          writes_rd;
        logic          uses_rs;
        logic          uses_rt;
    } decoded_t;

    // Unlisted encodings collapse to NOP so they neither stall nor write.
    function automatic logic [3:0] norm_opcode(input logic [3:0] op);
        case (op)
            OP_ST, OP_ADD, OP_INC, OP_NEG, OP_SUB, OP_J, OP_BRZ,
            OP_JM, OP_BRN, OP_LD, OP_SVPC: return op;
            default:                       return OP_NOP;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [3:0] op);
        case (op)
            OP_SVPC, OP_LD, OP_ADD, OP_INC, OP_NEG, OP_SUB: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs(input logic [3:0] op);
        case (op)
            OP_LD, OP_ST, OP_ADD, OP_INC, OP_NEG, OP_SUB,
            OP_J, OP_BRZ, OP_JM, OP_BRN: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rt(input logic [3:0] op);
        case (op)
            OP_ST, OP_ADD, OP_SUB: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

    function automatic decoded_t decode(input logic [DW-1:0] instr);
        decoded_t d;
        d.opcode    = norm_opcode(instr[OPC_LSB +: 4]);
        d.rd        = instr[RD_LSB +: AW];
        d.rs        = instr[RS_LSB +: AW];
        d.rt        = instr[RT_LSB +: AW];
        d.writes_rd = writes_rd(d.opcode);
        d.uses_rs   = uses_rs(d.opcode);
        d.uses_rt   = uses_rt(d.opcode);
        return d;
    endfunction

endpackage

// File: rtl/scu_issue_stage_if.sv
// Fetch, execute and writeback handshake bundle for scu_issue_stage.
// slave = the issue stage, master = its surrounding pipeline.
interface scu_issue_stage_if;
    import scu_isa_pkg::*;

    logic          if_valid;
    logic          if_ready;
    logic [DW-1:0] if_instr;
    logic          flush;
    logic          ex_valid;
    logic          ex_ready;
    logic [3:0]    ex_opcode;
    logic [AW-1:0] ex_rd;
    logic          ex_wrt;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;

    modport slave (
        input  if_valid, if_instr, flush, ex_ready, wb_valid, wb_rd,
        output if_ready, ex_valid, ex_opcode, ex_rd, ex_wrt
    );

    modport master (
        output if_valid, if_instr, flush, ex_ready, wb_valid, wb_rd,
        input  if_ready, ex_valid, ex_opcode, ex_rd, ex_wrt
    );

endinterface

// File: rtl/scu_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// writeback; a same-cycle set and clear of one register leaves it set.
module scu_scoreboard
    import scu_isa_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic [AW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_idx,
    input  logic [AW-1:0] rd_idx_a,
    input  logic [AW-1:0] rd_idx_b,
    input  logic [AW-1:0] rd_idx_c,
    output logic          hit_a,
    output logic          hit_b,
    output logic          hit_c
);

    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_d;

    always_comb begin
        sb_d = sb_q;
        if (clr_en) sb_d[clr_idx] = 1'b0;
        if (set_en) sb_d[set_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sb_q <= '0;
        else        sb_q <= sb_d;
    end

    assign hit_a = sb_q[rd_idx_a];
    assign hit_b = sb_q[rd_idx_b];
    assign hit_c = sb_q[rd_idx_c];

endmodule

// File: rtl/scu_issue_stage.sv
// Decode/issue stage: one-entry holding register, scoreboard hazard stall, ex handshake.
// Optional STALL_COUNT_EN adds a saturating stall-cycle counter on stall_count.
module scu_issue_stage
    import scu_isa_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    scu_issue_stage_if.slave  bus,
    output logic [AW-1:0]     rf_rs1,
    output logic [AW-1:0]     rf_rs2
`ifdef STALL_COUNT_EN
    ,
    output logic [31:0]       stall_count
`endif
);

    hold_state_e   state_q, state_d;
    logic [DW-1:0] instr_q;
    decoded_t      dec;
    logic          held;
    logic          hazard;
    logic          issue;
    logic          accept;
    logic          hit_rs, hit_rt, hit_rd;

    assign dec  = decode(instr_q);
    assign held = (state_q == ST_HELD);

    scu_scoreboard u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (issue && dec.writes_rd),
        .set_idx  (dec.rd),
        .clr_en   (bus.wb_valid),
        .clr_idx  (bus.wb_rd),
        .rd_idx_a (dec.rs),
        .rd_idx_b (dec.rt),
        .rd_idx_c (dec.rd),
        .hit_a    (hit_rs),
        .hit_b    (hit_rt),
        .hit_c    (hit_rd)
    );

    // Scoreboard is read registered, so a same-cycle writeback still stalls:
    // the register file would sample the stale value on this edge.
    assign hazard = (dec.uses_rs && hit_rs) || (dec.uses_rt && hit_rt) ||
                    (dec.writes_rd && hit_rd);
    assign issue  = held && !hazard && (!bus.ex_valid || bus.ex_ready) && !bus.flush;
    assign bus.if_ready = (!held || issue) && !bus.flush;
    assign accept = bus.if_valid && bus.if_ready;

    assign rf_rs1 = held ? dec.rs : '0;
    assign rf_rs2 = held ? dec.rt : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_HELD;
            ST_HELD: begin
                if (bus.flush)   state_d = ST_EMPTY;
                else if (accept) state_d = ST_HELD;
                else if (issue)  state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      instr_q <= '0;
        else if (accept) instr_q <= bus.if_instr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_valid  <= 1'b0;
            bus.ex_opcode <= '0;
            bus.ex_rd     <= '0;
            bus.ex_wrt    <= 1'b0;
        end else if (issue) begin
            bus.ex_valid  <= 1'b1;
            bus.ex_opcode <= dec.opcode;
            bus.ex_rd     <= dec.rd;
            bus.ex_wrt    <= dec.writes_rd;
        end else if (bus.ex_ready) begin
            bus.ex_valid  <= 1'b0;
        end
    end

`ifdef STALL_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (held && !issue && !bus.flush && (stall_count != '1))
            stall_count <= stall_count + 32'd1;
    end
`endif

endmodule

// File: doc/scu_issue_stage.md
Name: scu_issue_stage

Overview:
- Decode/issue stage directly upstream of the 64x32 register file.
- Holds one fetched instruction, decodes its fields and drives the register-file read addresses.
- Tracks pending destination writes in a 64-bit scoreboard and stalls on RAW/WAW hazards.
- Issues decoded control to the execute stage through a valid/ready handshake, timed so operand data from the register file's clocked read lines up with ex_valid.

Parameters:
- NREG, 64, number of architectural registers (scoreboard depth).
- AW, 6, register address width.
- DW, 32, instruction width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch offers if_instr
- if_ready  out  1  stage accepts if_instr this cycle
- if_instr  in  DW  instruction word
- flush  in  1  discard held instruction (branch taken)
- rf_rs1  out  AW  register-file read address 1 (instr[21:16])
- rf_rs2  out  AW  register-file read address 2 (instr[15:10])
- ex_valid  out  1  execute-stage outputs valid
- ex_ready  in  1  execute stage consumes ex_* this cycle
- ex_opcode  out  4  issued opcode
- ex_rd  out  AW  issued destination
- ex_wrt  out  1  issued instruction writes rd
- wb_valid  in  1  writeback occurring this cycle
- wb_rd  in  AW  writeback destination
- stall_count  out  32  stall cycles (only with STALL_COUNT_EN)

Behaviour:
- Field layout: opcode = instr[31:28], rd = [27:22], rs = [21:16], rt = [15:10].
- Opcodes:
  - NOP 0000, ST 0011, ADD 0100, INC 0101, NEG 0110, SUB 0111
  - J 1000, BRZ 1001, JM 1010, BRN 1011, LD 1110, SVPC 1111
  - Any other opcode is treated as NOP.
- writes_rd: SVPC, LD, ADD, INC, NEG, SUB.
- uses_rs: LD, ST, ADD, INC, NEG, SUB, J, BRZ, JM, BRN.
- uses_rt: ST, ADD, SUB.
- Holding register: states EMPTY and HELD.
  - EMPTY -> HELD on if_valid && if_ready.
  - HELD -> EMPTY on issue without a new accept.
  - HELD -> HELD on issue plus a same-cycle accept.
- hazard = (uses_rs && sb[rs]) || (uses_rt && sb[rt]) || (writes_rd && sb[rd]).
- issue = HELD && !hazard && (!ex_valid || ex_ready) && !flush.
- if_ready = EMPTY || issue. This is combinational, so a back-to-back accept occurs on the issue cycle.
- rf_rs1/rf_rs2 are driven combinationally from the held instruction (0 when EMPTY). The register file samples them on the issue edge, so its rsOut/rtOut is valid in the first cycle ex_valid is high.
- ex_* registers load on issue. ex_valid clears when ex_ready && !issue.
- Scoreboard:
  - On issue with writes_rd, set sb[rd].
  - On wb_valid, clear sb[wb_rd].
  - Same register set and cleared in one cycle: set wins.
- Writeback same cycle as a hazard: the stage still stalls that cycle, because the register file reads the old value on that edge. Issue occurs the next cycle.
- flush:
  - Drops the held instruction (-> EMPTY) and suppresses that cycle's issue and accept.
  - Does not clear the scoreboard or ex_valid; in-flight writes still retire.
- Reset (async, active-low):
  - State EMPTY; sb = 0.
  - ex_valid = 0, ex_opcode = 0, ex_rd = 0, ex_wrt = 0.
  - if_ready = 1 after reset; stall_count = 0.
- Reset mid-stall discards the held instruction and all scoreboard bits.

Optional Feature:
- STALL_COUNT_EN defined:
  - stall_count increments each cycle HELD && !issue && !flush.
  - Saturates at 0xFFFFFFFF; reset to 0.
- Undefined: the stall_count port and its counter are absent.

Decomposition:
- Package scu_isa_pkg holds:
  - opcode localparams
  - field bit positions
  - AW/DW constants
  - decode function(s) for writes_rd/uses_rs/uses_rt
- Sub-module scu_scoreboard: 64-bit set/clear vector with set-wins priority, single read port per operand.

Test Plan:
- Reset release with if_valid=0 -> if_ready=1, ex_valid=0, sb=0; after accepting ADD x3,x10,x11 (0x40CA2C00) -> rf_rs1=10, rf_rs2=11, issue next cycle, ex_rd=3, ex_wrt=1, sb[3]=1.
- ADD x3 then SUB x4,x3,x11 -> SUB holds, if_ready=0 until wb_valid wb_rd=3. It issues the cycle after writeback, not the same cycle.
- ex_ready=0 with ex_valid=1 -> next instruction held, if_ready=0. ex_ready=1 -> issue and accept in the same cycle.
- LD x5 issued, then ADD x5 with wb_valid wb_rd=5 in the issue cycle of a new writer of x5 -> sb[5] remains 1 (set wins).
- flush while HELD with hazard -> state EMPTY next cycle, sb unchanged, ex_valid unaffected, no issue.
- STALL_COUNT_EN: a 3-cycle RAW stall -> stall_count=3; async rst_n low mid-stall -> all outputs at reset values immediately.
